// File: rtl/axis_gmii_tx_arb.sv
// axis_gmii_tx_arb
// Frame-granular round-robin arbiter that shares one 8-bit AXI-Stream
// transmit path among PORTS sources. A grant lasts from the first beat of
// a frame until its tlast beat is accepted. Per-port frame and error counters
// are kept for software status.
module axis_gmii_tx_arb #(
    parameter int PORTS     = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [8*PORTS-1:0]           s_axis_tdata,
    input  logic [PORTS-1:0]             s_axis_tvalid,
    output logic [PORTS-1:0]             s_axis_tready,
    input  logic [PORTS-1:0]             s_axis_tlast,
    input  logic [PORTS-1:0]             s_axis_tuser,

    output logic [7:0]                   m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,

    input  logic [PORTS-1:0]             port_enable,
    output logic [PORTS-1:0]             grant,
    output logic                         busy,
    output logic [CNT_WIDTH*PORTS-1:0]   frame_count,
    output logic [CNT_WIDTH*PORTS-1:0]   error_count
);

    localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                       state_r;
    state_t                       state_next_s;
    logic [PORTS-1:0]             grant_r;
    logic [IDX_W-1:0]             last_r;
    logic [CNT_WIDTH*PORTS-1:0]   frame_count_r;
    logic [CNT_WIDTH*PORTS-1:0]   error_count_r;

    logic [PORTS-1:0]             req_s;
    logic [IDX_W-1:0]             cand_s;
    logic [IDX_W-1:0]             pick_idx_s;
    logic                         pick_found_s;
    logic [PORTS-1:0]             pick_onehot_s;
    logic                         accept_s;
    logic                         accept_last_s;

    // Only enabled sources with data take part in arbitration.
    assign req_s         = s_axis_tvalid & port_enable;
    assign pick_onehot_s = {{(PORTS-1){1'b0}}, 1'b1} << pick_idx_s;
    assign accept_s      = m_axis_tvalid & m_axis_tready;
    assign accept_last_s = accept_s & m_axis_tlast;

    // Round-robin search: first requester at or after last+1, wrapping.
    always_comb begin
        pick_idx_s   = last_r;
        pick_found_s = 1'b0;
        cand_s       = last_r;
        for (int off = 32'sd1; off <= PORTS; off++) begin
            cand_s = IDX_W'((int'(last_r) + off) % PORTS);
            if (!pick_found_s && req_s[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // Output mux driven from the registered grant index; nothing passes when idle.
    always_comb begin
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = {PORTS{1'b0}};
        if (state_r == ST_ACTIVE) begin
            m_axis_tdata          = s_axis_tdata[{last_r, 3'b000} +: 8];
            m_axis_tvalid         = s_axis_tvalid[last_r];
            m_axis_tlast          = s_axis_tlast[last_r];
            m_axis_tuser          = s_axis_tuser[last_r];
            s_axis_tready[last_r] = m_axis_tready;
        end else begin
            m_axis_tdata  = 8'h00;
            m_axis_tvalid = 1'b0;
            m_axis_tlast  = 1'b0;
            m_axis_tuser  = 1'b0;
            s_axis_tready = {PORTS{1'b0}};
        end
    end

    // Next-state logic: grant on any request, release after the tlast beat.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (accept_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            grant_r <= {PORTS{1'b0}};
            last_r  <= IDX_W'(PORTS - 1);
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_IDLE) && pick_found_s) begin
                grant_r <= pick_onehot_s;
                last_r  <= pick_idx_s;
            end else if (accept_last_s) begin
                grant_r <= {PORTS{1'b0}};
            end
        end
    end

    // Per-port completed-frame and bad-frame counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count_r <= {(CNT_WIDTH*PORTS){1'b0}};
            error_count_r <= {(CNT_WIDTH*PORTS){1'b0}};
        end else begin
            for (int i = 32'sd0; i < PORTS; i++) begin
                if (accept_last_s && (last_r == IDX_W'(i))) begin
                    frame_count_r[i*CNT_WIDTH +: CNT_WIDTH] <=
                        frame_count_r[i*CNT_WIDTH +: CNT_WIDTH] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    if (m_axis_tuser) begin
                        error_count_r[i*CNT_WIDTH +: CNT_WIDTH] <=
                            error_count_r[i*CNT_WIDTH +: CNT_WIDTH] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
            end
        end
    end

    assign grant       = grant_r;
    assign busy        = (state_r == ST_ACTIVE);
    assign frame_count = frame_count_r;
    assign error_count = error_count_r;

endmodule

// File: tb/tb_axis_gmii_tx_arb.sv
// Testbench for axis_gmii_tx_arb: a directed vector table, hand-written
// multi-cycle sequences and a randomized run, all compared against a
// frame-level round-robin model kept in the bench.
module tb_axis_gmii_tx_arb;

    localparam int PORTS = 2;
    localparam int CW    = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [8*PORTS-1:0]    s_tdata;
    logic [PORTS-1:0]      s_tvalid;
    logic [PORTS-1:0]      s_tready;
    logic [PORTS-1:0]      s_tlast;
    logic [PORTS-1:0]      s_tuser;
    logic [7:0]            m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;
    logic                  m_tuser;
    logic [PORTS-1:0]      port_enable;
    logic [PORTS-1:0]      grant;
    logic                  busy;
    logic [CW*PORTS-1:0]   frame_count;
    logic [CW*PORTS-1:0]   error_count;

    always #5 clk = ~clk;

    axis_gmii_tx_arb #(.PORTS(PORTS), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .port_enable   (port_enable),
        .grant         (grant),
        .busy          (busy),
        .frame_count   (frame_count),
        .error_count   (error_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level model state
    int   owner;
    int   mlast;
    int   mfc [PORTS];
    int   mec [PORTS];
    int   acc_port;
    int   dut_xfers;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    beat_t            srcq [PORTS][$];
    logic [PORTS-1:0] glog [$];

    typedef struct packed {
        logic [1:0] tv;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] tl;
        logic [1:0] tu;
        logic [1:0] en;
        logic       mr;
        logic [1:0] eg;
        logic       emv;
        logic [7:0] emd;
        logic       eml;
        logic       emu;
        logic [1:0] ert;
        logic [3:0] efc0;
        logic [3:0] efc1;
        logic [3:0] eec0;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        s_tvalid    = '0;
        s_tdata     = '0;
        s_tlast     = '0;
        s_tuser     = '0;
        port_enable = '1;
        m_tready    = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        owner = -1;
        mlast = PORTS - 1;
        for (int i = 0; i < PORTS; i++) begin
            mfc[i] = 0;
            mec[i] = 0;
            srcq[i].delete();
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic cycle();
        logic [PORTS-1:0] eg;
        logic [PORTS-1:0] er;
        #1;
        eg = '0;
        er = '0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            if (m_tready) er[owner] = 1'b1;
        end
        check("grant", grant, eg);
        check("busy", busy, owner >= 0);
        check("s_tready", s_tready, er);
        if (owner >= 0 && s_tvalid[owner]) begin
            check("m_tvalid", m_tvalid, 1);
            check("m_tdata", m_tdata, s_tdata[owner*8 +: 8]);
            check("m_tlast", m_tlast, s_tlast[owner]);
            check("m_tuser", m_tuser, s_tuser[owner]);
        end else begin
            check("m_tvalid_idle", m_tvalid, 0);
        end
        for (int i = 0; i < PORTS; i++) begin
            check("frame_count", frame_count[i*CW +: CW], mfc[i]);
            check("error_count", error_count[i*CW +: CW], mec[i]);
        end
        if (m_tvalid && m_tready) dut_xfers++;
        glog.push_back(grant);
        @(posedge clk);
        acc_port = -1;
        if (rst) begin
            owner = -1;
            mlast = PORTS - 1;
            for (int i = 0; i < PORTS; i++) begin
                mfc[i] = 0;
                mec[i] = 0;
            end
        end else if (owner >= 0) begin
            if (s_tvalid[owner] && m_tready) begin
                acc_port = owner;
                if (s_tlast[owner]) begin
                    mfc[owner] = (mfc[owner] + 1) % (1 << CW);
                    if (s_tuser[owner]) mec[owner] = (mec[owner] + 1) % (1 << CW);
                    owner = -1;
                end
            end
        end else begin
            for (int k = 1; k <= PORTS; k++) begin
                int c;
                c = (mlast + k) % PORTS;
                if (owner < 0 && s_tvalid[c] && port_enable[c]) begin
                    owner = c;
                    mlast = c;
                end
            end
        end
        @(negedge clk);
    endtask

    // Drive sources from their frame queues; rnd adds stalls, refills and resets.
    task automatic drive_from_queues(input int ncyc, input bit rnd);
        bit drained;
        drained = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (rnd) begin
                for (int p = 0; p < PORTS; p++) begin
                    if (srcq[p].size() == 0 && $urandom_range(0, 2) == 0) begin
                        int len;
                        len = $urandom_range(1, 4);
                        for (int b = 0; b < len; b++) begin
                            beat_t bt;
                            bt.d = 8'($urandom);
                            bt.l = (b == len - 1);
                            bt.u = (b == len - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
                            srcq[p].push_back(bt);
                        end
                    end
                end
                m_tready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 49) == 0) port_enable = PORTS'($urandom_range(0, 3));
                rst = ($urandom_range(0, 299) == 0);
            end else if (srcq[0].size() == 0 && srcq[1].size() == 0 && owner < 0) begin
                drained = 1'b1;
                break;
            end
            for (int p = 0; p < PORTS; p++) begin
                if (srcq[p].size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                    s_tvalid[p]        = 1'b1;
                    s_tdata[p*8 +: 8]  = srcq[p][0].d;
                    s_tlast[p]         = srcq[p][0].l;
                    s_tuser[p]         = srcq[p][0].u;
                end else begin
                    s_tvalid[p]        = 1'b0;
                    s_tdata[p*8 +: 8]  = 8'($urandom);
                    s_tlast[p]         = 1'($urandom);
                    s_tuser[p]         = 1'($urandom);
                end
            end
            cycle();
            if (acc_port >= 0) void'(srcq[acc_port].pop_front());
        end
        rst = 1'b0;
        if (!rnd) check("drain_timeout", drained, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PORTS-1:0] seq [$];
        int               gaps [$];
        int               zrun;
        logic [PORTS-1:0] prev;
        int               idx;

        // tv  d0     d1     tl    tu    en    mr  | eg   emv emd   eml emu ert  fc0 fc1 ec0
        tbl[0]  = '{2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 4'd0};
        tbl[1]  = '{2'b01, 8'hA1, 8'h00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 4'd0};
        tbl[2]  = '{2'b01, 8'hA1, 8'h00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b01, 1'b1, 8'hA1, 1'b0, 1'b0, 2'b01, 4'd0, 4'd0, 4'd0};
        tbl[3]  = '{2'b01, 8'hA2, 8'h00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b01, 1'b1, 8'hA2, 1'b0, 1'b0, 2'b01, 4'd0, 4'd0, 4'd0};
        tbl[4]  = '{2'b01, 8'hA3, 8'h00, 2'b01, 2'b00, 2'b11, 1'b1, 2'b01, 1'b1, 8'hA3, 1'b1, 1'b0, 2'b01, 4'd0, 4'd0, 4'd0};
        tbl[5]  = '{2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd1, 4'd0, 4'd0};
        tbl[6]  = '{2'b01, 8'hB1, 8'h00, 2'b01, 2'b01, 2'b11, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd1, 4'd0, 4'd0};
        tbl[7]  = '{2'b01, 8'hB1, 8'h00, 2'b01, 2'b01, 2'b11, 1'b1, 2'b01, 1'b1, 8'hB1, 1'b1, 1'b1, 2'b01, 4'd1, 4'd0, 4'd0};
        tbl[8]  = '{2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd2, 4'd0, 4'd1};
        tbl[9]  = '{2'b11, 8'hC1, 8'hD1, 2'b11, 2'b00, 2'b01, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd2, 4'd0, 4'd1};
        tbl[10] = '{2'b11, 8'hC1, 8'hD1, 2'b11, 2'b00, 2'b01, 1'b1, 2'b01, 1'b1, 8'hC1, 1'b1, 1'b0, 2'b01, 4'd2, 4'd0, 4'd1};
        tbl[11] = '{2'b11, 8'hC1, 8'hD1, 2'b11, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd3, 4'd0, 4'd1};
        tbl[12] = '{2'b11, 8'hC1, 8'hD1, 2'b11, 2'b00, 2'b11, 1'b1, 2'b10, 1'b1, 8'hD1, 1'b1, 1'b0, 2'b10, 4'd3, 4'd0, 4'd1};
        tbl[13] = '{2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 4'd3, 4'd1, 4'd1};

        dut_xfers = 0;
        idle_inputs();

        // Directed vector table
        do_reset();
        for (int r = 0; r < 14; r++) begin
            s_tvalid    = tbl[r].tv;
            s_tdata     = {tbl[r].d1, tbl[r].d0};
            s_tlast     = tbl[r].tl;
            s_tuser     = tbl[r].tu;
            port_enable = tbl[r].en;
            m_tready    = tbl[r].mr;
            #1;
            check("tbl_grant", grant, tbl[r].eg);
            check("tbl_busy", busy, tbl[r].eg != 2'b00);
            check("tbl_m_tvalid", m_tvalid, tbl[r].emv);
            if (tbl[r].emv) check("tbl_m_tdata", m_tdata, tbl[r].emd);
            check("tbl_m_tlast", m_tlast, tbl[r].eml);
            check("tbl_m_tuser", m_tuser, tbl[r].emu);
            check("tbl_s_tready", s_tready, tbl[r].ert);
            check("tbl_fc0", frame_count[3:0], tbl[r].efc0);
            check("tbl_fc1", frame_count[7:4], tbl[r].efc1);
            check("tbl_ec0", error_count[3:0], tbl[r].eec0);
            @(negedge clk);
        end

        // Both ports offering 2-beat frames back to back: strict alternation
        do_reset();
        for (int p = 0; p < PORTS; p++) begin
            for (int f = 0; f < 2; f++) begin
                for (int b = 0; b < 2; b++) begin
                    beat_t bt;
                    bt.d = 8'(8'h50 + p*16 + f*2 + b);
                    bt.l = (b == 1);
                    bt.u = 1'b0;
                    srcq[p].push_back(bt);
                end
            end
        end
        glog.delete();
        drive_from_queues(60, 1'b0);
        zrun = 0;
        prev = '0;
        foreach (glog[k]) begin
            if (glog[k] != '0 && glog[k] != prev) begin
                if (seq.size() > 0) gaps.push_back(zrun);
                seq.push_back(glog[k]);
                zrun = 0;
            end else if (glog[k] == '0) begin
                zrun++;
            end
            prev = glog[k];
        end
        check("alt_frames", seq.size(), 4);
        for (int k = 0; k < seq.size() && k < 4; k++)
            check("alt_order", seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        foreach (gaps[k]) check("alt_bubble", gaps[k], 1);
        check("alt_fc0", frame_count[3:0], 2);
        check("alt_fc1", frame_count[7:4], 2);

        // Port 1 drops tvalid mid-frame while port 0 keeps requesting
        do_reset();
        s_tvalid = 2'b10; s_tdata = {8'hE1, 8'h00}; s_tlast = 2'b00;
        cycle();
        cycle();
        for (int k = 0; k < 5; k++) begin
            s_tvalid = 2'b01; s_tdata = {8'h00, 8'hF1}; s_tlast = 2'b01;
            cycle();
            check("drop_hold_grant", grant, 2'b10);
            check("drop_rdy0", s_tready[0], 0);
        end
        s_tvalid = 2'b11; s_tdata = {8'hE2, 8'hF1}; s_tlast = 2'b11;
        cycle();
        check("drop_release", grant, 2'b00);
        s_tvalid = 2'b01;
        cycle();
        check("drop_next_port0", grant, 2'b01);
        cycle();
        s_tvalid = 2'b00;
        cycle();

        // tready toggling during a 4-beat frame, then reset mid-frame
        do_reset();
        dut_xfers = 0;
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            s_tvalid = 2'b01;
            s_tdata  = {8'h00, 8'(8'h30 + idx)};
            s_tlast  = {1'b0, idx == 3};
            m_tready = (c % 2 == 0);
            cycle();
            if (acc_port == 0) idx++;
        end
        check("tgl_beats_model", idx, 4);
        check("tgl_xfers", dut_xfers, 4);
        s_tvalid = 2'b00; m_tready = 1'b1;
        cycle();
        check("tgl_fc0", frame_count[3:0], 1);
        s_tvalid = 2'b01; s_tdata = {8'h00, 8'h40}; s_tlast = 2'b00;
        cycle();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_fc", frame_count, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        s_tvalid = 2'b00;
        cycle();

        // Randomized traffic with stalls, enable changes and occasional resets
        do_reset();
        drive_from_queues(3000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
